// File: rtl/wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter
//
// Round-robin arbiter sharing one Wishbone classic master port among NUM_REQ
// requesters. A granted requester's command is latched and driven onto the bus
// as a single read or write cycle. Read data and the termination status are
// captured, and a one-cycle done pulse goes back to the owning requester.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable a bus-cycle watchdog.
// A bus cycle that sees no termination within TIMEOUT clocks then ends with
// status 3. Without the macro the block waits for a termination forever.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   TIMEOUT  watchdog limit in clocks (1..65535), used with WB_ARB_TIMEOUT_EN
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req             per-requester request, held until its done pulse
//   we_i/adr_i/     per-requester command: write enable, address,
//   dat_i/sel_i     write data and byte selects (32/32/4-bit slices)
//   gnt             one-hot current owner (or zero)
//   done            one-cycle completion pulse to the owner
//   rdata, status   read data and termination code (0 ack, 1 err, 2 rty,
//                   3 timeout), valid while done is high
//   adr/dout/sel/we Wishbone master outputs
//   cyc, stb        Wishbone cycle / strobe
//   din             Wishbone read data
//   ack, err, rty   Wishbone terminations
// -----------------------------------------------------------------------------
module wishbone_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     we_i,
  input  logic [32*NUM_REQ-1:0]  adr_i,
  input  logic [32*NUM_REQ-1:0]  dat_i,
  input  logic [4*NUM_REQ-1:0]   sel_i,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [31:0]            rdata,
  output logic [1:0]             status,
  output logic [31:0]            adr,
  input  logic [31:0]            din,
  output logic [31:0]            dout,
  output logic                   cyc,
  output logic                   stb,
  output logic [3:0]             sel,
  output logic                   we,
  input  logic                   ack,
  input  logic                   err,
  input  logic                   rty
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] ST_ACK = 2'd0;
  localparam logic [1:0] ST_ERR = 2'd1;
  localparam logic [1:0] ST_RTY = 2'd2;

  // Requester 0 wins the first search after reset.
  localparam logic [IW-1:0]      LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Per-requester views of the packed command buses.
  logic [NUM_REQ-1:0][31:0] adr_arr_s;
  logic [NUM_REQ-1:0][31:0] dat_arr_s;
  logic [NUM_REQ-1:0][3:0]  sel_arr_s;

  assign adr_arr_s = adr_i;
  assign dat_arr_s = dat_i;
  assign sel_arr_s = sel_i;

  logic [1:0]         state_q,      state_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] gnt_q,        gnt_d;
  logic [NUM_REQ-1:0] done_q,       done_d;
  logic [31:0]        rdata_q,      rdata_d;
  logic [1:0]         status_q,     status_d;
  logic [31:0]        adr_q,        adr_d;
  logic [31:0]        dout_q,       dout_d;
  logic [3:0]         sel_q,        sel_d;
  logic               we_q,         we_d;
  logic               cyc_q,        cyc_d;

  logic               found_s;
  logic [IW-1:0]      pick_s;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [1:0]  ST_TMO   = 2'd3;
  // Counter starts at 0 on the grant edge, so the limit is hit on the
  // TIMEOUT-th BUS edge when the count equals TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]        cnt_q,        cnt_d;
`else
  logic               unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT != 0);
`endif

  // Round-robin search: first pending requester after the last one served.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    found_s = 1'b0;
    pick_s  = last_grant_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_grant_q) + i) % NUM_REQ;
      cand_idx = IW'(cand);
      if (req[cand_idx] && !found_s) begin
        found_s = 1'b1;
        pick_s  = cand_idx;
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Next-state logic for the grant / bus / completion sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    done_d       = done_q;
    rdata_d      = rdata_q;
    status_d     = status_q;
    adr_d        = adr_q;
    dout_d       = dout_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d      = S_BUS;
          last_grant_d = pick_s;
          gnt_d        = ONE_HOT0 << pick_s;
          cyc_d        = 1'b1;
          we_d         = we_i[pick_s];
          adr_d        = adr_arr_s[pick_s];
          dout_d       = dat_arr_s[pick_s];
          sel_d        = sel_arr_s[pick_s];
`ifdef WB_ARB_TIMEOUT_EN
          cnt_d        = 16'd0;
`endif
        end else begin
          state_d      = S_IDLE;
        end
      end
      S_BUS: begin
        if (ack || err || rty) begin
          state_d  = S_DONE;
          cyc_d    = 1'b0;
          done_d   = gnt_q;
          status_d = ack ? ST_ACK : (err ? ST_ERR : ST_RTY);
          // Only a successful read carries data back.
          if (ack && !we_q) begin
            rdata_d = din;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            state_d  = S_DONE;
            cyc_d    = 1'b0;
            done_d   = gnt_q;
            status_d = ST_TMO;
          end else begin
            cnt_d    = cnt_q + 16'd1;
          end
`else
          state_d = S_BUS;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = {NUM_REQ{1'b0}};
        gnt_d   = {NUM_REQ{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        done_d  = {NUM_REQ{1'b0}};
        gnt_d   = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_RST;
      gnt_q        <= {NUM_REQ{1'b0}};
      done_q       <= {NUM_REQ{1'b0}};
      rdata_q      <= 32'd0;
      status_q     <= 2'd0;
      adr_q        <= 32'd0;
      dout_q       <= 32'd0;
      sel_q        <= 4'd0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
      adr_q        <= adr_d;
      dout_q       <= dout_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign status = status_q;
  assign adr    = adr_q;
  assign dout   = dout_q;
  assign sel    = sel_q;
  assign we     = we_q;
  assign cyc    = cyc_q;
  assign stb    = cyc_q;

endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Shares one Wishbone classic master port among `NUM_REQ` testbench requesters, such as register-access drivers for each UART channel, using round-robin arbitration. Each granted request runs as a single read or write cycle. The block latches the requester's command, drives the bus, and captures read data and the termination status. It then returns a one-cycle completion pulse to the owning requester. It sits between the per-channel access drivers and the shared Wishbone fabric, and replaces direct calls into the single bus-master task model.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `TIMEOUT`, default 255: bus-cycle watchdog limit in clocks, legal range 1..65535. Used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1: the block's single clock.
- `rst`  in  1: asynchronous, active-low reset. Asserted when 0.
- `req`  in  `NUM_REQ`: request per requester. Held high until that requester's `done` pulse.
- `we_i`  in  `NUM_REQ`: per requester, 1 = write, 0 = read.
- `adr_i`  in  32*`NUM_REQ`: address; requester k occupies bits [32k+31:32k].
- `dat_i`  in  32*`NUM_REQ`: write data, same packing as `adr_i`.
- `sel_i`  in  4*`NUM_REQ`: byte selects, packed in 4-bit slices.
- `gnt`  out  `NUM_REQ`: one-hot current owner, or all zero.
- `done`  out  `NUM_REQ`: one-cycle completion pulse to the owner.
- `rdata`  out  32: read data, valid while `done` is high.
- `status`  out  2: termination code, valid while `done` is high. 0 = ack, 1 = err, 2 = rty, 3 = timeout.
- `adr`  out  32: Wishbone address.
- `din`  in  32: Wishbone read data.
- `dout`  out  32: Wishbone write data.
- `cyc`, `stb`  out  1 each: Wishbone cycle and strobe.
- `sel`  out  4: Wishbone byte selects.
- `we`  out  1: Wishbone write enable.
- `ack`, `err`, `rty`  in  1 each: Wishbone cycle terminations.

## Operation

- The FSM has three states: IDLE, BUS and DONE.
- **IDLE:** if any `req` bit is high, grant the requester found first by a round-robin search.
  - The search starts at (`last_grant` + 1) mod `NUM_REQ`.
  - At the granting edge, latch that requester's `we_i`/`adr_i`/`dat_i`/`sel_i` onto `we`/`adr`/`dout`/`sel`.
  - At the same edge set `cyc` = `stb` = 1, set `gnt`, update `last_grant`, and move to BUS.
- **BUS:** hold all bus outputs stable.
  - On the first edge where any of `ack`/`err`/`rty` is high, clear `cyc`/`stb` and set `done[owner]`.
  - At that edge load `status` using priority ack > err > rty.
  - If ack is high and `we` = 0, load `rdata` from `din`; otherwise `rdata` keeps its previous value.
  - Move to DONE.
- **DONE:** `done` is high for exactly this one cycle.
  - At the next edge clear `done` and `gnt`, then return to IDLE.
  - Requesters drop `req` on the edge at which they sample `done` = 1.
  - A `req` still high in IDLE is treated as a new request.
- **Latched command:** changes on `req`/`adr_i`/`dat_i` belonging to the owner are ignored while in BUS.
- **Dropped request:** a `req` that falls before being granted is simply never granted. There is no error for this.
- **Reset values:** all outputs are 0 and the FSM is in IDLE.
  - `last_grant` resets to `NUM_REQ`-1, so requester 0 wins first.
  - A reset asserted mid-cycle drops `cyc`/`stb` immediately and asynchronously. No `done` is issued.

## Timing

- **Grant latency:** `req` sampled high at edge 0 (in IDLE) gives `cyc`/`stb` high from edge 0.
- **Zero-wait slave:** `ack` high in the first `cyc` cycle is sampled at edge 1. `cyc` falls and `done` rises at edge 1, and `done` falls at edge 2.
- **Back-to-back throughput:** minimum one bus cycle per 3 clocks (grant, ack, DONE). `cyc` is low for at least 2 clocks between cycles.
- **Simultaneous requests:** when all requesters are pending, grant order is strictly rotating, with no starvation. The worst-case wait is `NUM_REQ`-1 transactions.
- **Multiple terminations:** `ack`/`err`/`rty` asserted together in the same cycle resolve by priority (ack > err > rty).
- **Terminations outside BUS:** ignored.

## Configuration

- **`WB_ARB_TIMEOUT_EN` defined:** a 16-bit counter clears on entry to BUS and increments each BUS cycle.
  - If it reaches `TIMEOUT` with no termination, the block clears `cyc`/`stb`, sets `status` = 3, pulses `done` and enters DONE.
  - If a termination arrives on the same edge as the timeout, the termination wins.
- **Macro undefined:** no counter exists and BUS waits indefinitely. `status` never takes the value 3.

## Test plan

- **Single write:** req[0], we = 1, adr 0x0000_0010, dat 0xA5, sel 0b0001; slave acks after 2 wait states.
  - Required: bus shows those values with `cyc` high for 3 clocks.
  - Required: `done[0]` pulses once with `status` = 0.
- **Read:** req[2], we = 0, adr 0x14; slave returns 0x0000_0060 with ack.
  - Required: `rdata` = 0x60 and `status` = 0 in the `done[2]` cycle.
- **Contention:** all 4 `req` raised at the same edge out of reset, each re-raised after its `done`.
  - Required: grant order 0, 1, 2, 3, 0, 1.
  - Required: `gnt` is one-hot on every owned cycle and `cyc` is low for at least 2 clocks between cycles.
- **Error/retry:** slave asserts `err` and `rty` together.
  - Required: `status` = 1.
  - With `rty` alone: `status` = 2. `rdata` is unchanged in both cases.
- **Timeout (macro on, `TIMEOUT` = 8):** slave never responds.
  - Required: `cyc` falls after 8 BUS cycles and `status` = 3.
  - With the macro off: `cyc` is still high after 1000 cycles.
- **Reset mid-cycle:** `rst` = 0 while `cyc` = 1.
  - Required: all outputs read 0 asynchronously and no `done` is issued.
  - Required: the first grant after release goes to requester 0.
